// File: rtl/tx_samp_player.sv
// tx_samp_player: CPU-filled ping-pong I/Q sample buffer, replayed one
// de-interleaved frame (all channels) per samp_tick toward the DUC.
// Build option: TX_UNDERRUN_HOLD_EN -- underrun frames repeat the last
// emitted I/Q of each channel instead of emitting zeros.
module tx_samp_player #(
  parameter  int unsigned TX_CHANS = 2,
  parameter  int unsigned BANK_L2  = 9,
  parameter  int unsigned DW       = 16,
  localparam int unsigned CW       = (TX_CHANS > 1) ? $clog2(TX_CHANS) : 1
) (
  input  logic          adc_clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          set_nsamps,
  input  logic [6:0]    nsamps_in,
  input  logic          commit,
  input  logic          samp_tick,
  output logic          out_valid,
  output logic [CW-1:0] out_chan,
  output logic [DW-1:0] out_i,
  output logic [DW-1:0] out_q,
  output logic          srq,
  input  logic          srq_ack,
  output logic          underrun,
  output logic          full
);

  localparam int unsigned BW = 1 << BANK_L2;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_I, S_RD_Q, S_EMIT, S_FRAME_END
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_fill_bank;
  logic              w_play_bank;
  logic [1:0]        r_bank_full, w_bank_full_nxt;
  logic              r_full;
  logic [BANK_L2:0]  r_waddr;
  logic [BANK_L2-1:0] r_raddr;
  logic [6:0]        r_nsamps, r_nsamps_act, r_fcnt;
  logic [CW-1:0]     r_ch;
  logic              r_urun;
  logic [DW-1:0]     r_rdata, r_i_cap;
  logic [DW-1:0]     r_mem [2*BW];
  logic              r_srq, r_underrun, r_out_valid;
  logic [CW-1:0]     r_out_chan;
  logic [DW-1:0]     r_out_i, r_out_q;
  logic              w_start, w_rd, w_cap_i, w_emit, w_fend, w_urun_evt;
  logic              w_wr, w_commit, w_drain, w_swap;
`ifdef TX_UNDERRUN_HOLD_EN
  logic [DW-1:0]     r_hold_i [TX_CHANS];
  logic [DW-1:0]     r_hold_q [TX_CHANS];
`endif

  assign w_play_bank = ~r_fill_bank;
  // A full fill bank blocks writes/commits; this also covers full = 1.
  assign w_wr        = wr_en & ~r_bank_full[r_fill_bank] & ~r_waddr[BANK_L2];
  assign w_commit    = commit & ~r_full & ~r_bank_full[r_fill_bank];
  assign w_drain     = w_fend & ~r_urun & (r_fcnt == r_nsamps_act);
  // Swap when a committed fill bank waits on an empty play bank, or at drain.
  assign w_swap      = (r_bank_full[r_fill_bank] & ~r_bank_full[w_play_bank]) |
                       (w_drain & r_bank_full[r_fill_bank]);

  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;
  assign out_i     = r_out_i;
  assign out_q     = r_out_q;
  assign srq       = r_srq;
  assign underrun  = r_underrun;
  assign full      = r_full;

  // Player state register.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Player next-state and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rd        = 1'b0;
    w_cap_i     = 1'b0;
    w_emit      = 1'b0;
    w_fend      = 1'b0;
    w_urun_evt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (samp_tick) begin
          w_start     = 1'b1;
          w_urun_evt  = ~r_bank_full[w_play_bank];
          w_state_nxt = S_RD_I;
        end
      end
      S_RD_I: begin
        w_rd        = 1'b1;
        w_state_nxt = S_RD_Q;
      end
      S_RD_Q: begin
        w_rd        = 1'b1;
        w_cap_i     = 1'b1;
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        w_emit      = 1'b1;
        w_state_nxt = (r_ch == CW'(TX_CHANS - 1)) ? S_FRAME_END : S_RD_I;
      end
      S_FRAME_END: begin
        w_fend      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (samp_tick && (r_state != S_IDLE)) w_urun_evt = 1'b1;
  end

  // Next bank-full flags: commit fills, drain empties.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_commit) w_bank_full_nxt[r_fill_bank] = 1'b1;
    if (w_drain)  w_bank_full_nxt[w_play_bank] = 1'b0;
  end

  // Bank bookkeeping, fill pointer, frame-count config and service request.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      r_fill_bank  <= 1'b0;
      r_bank_full  <= 2'b00;
      r_full       <= 1'b0;
      r_waddr      <= '0;
      r_nsamps     <= '0;
      r_nsamps_act <= '0;
      r_srq        <= 1'b1;
    end else begin
      r_bank_full <= w_bank_full_nxt;
      r_full      <= &w_bank_full_nxt;
      if (w_swap) begin
        r_fill_bank  <= ~r_fill_bank;
        r_nsamps_act <= r_nsamps;
      end
      if (w_commit)  r_waddr <= '0;
      else if (w_wr) r_waddr <= r_waddr + (BANK_L2 + 1)'(1);
      if (set_nsamps) r_nsamps <= nsamps_in;
      if (w_drain)      r_srq <= 1'b1;
      else if (srq_ack) r_srq <= 1'b0;
    end
  end

  // Sample RAM: CPU write port, registered read port on the play bank.
  always_ff @(posedge adc_clk) begin
    if (w_wr) r_mem[{r_fill_bank, r_waddr[BANK_L2-1:0]}] <= wr_data;
    r_rdata <= r_mem[{w_play_bank, r_raddr}];
  end

  // Player datapath: read pointer, frame counter, output registers.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      r_raddr     <= '0;
      r_fcnt      <= '0;
      r_ch        <= '0;
      r_urun      <= 1'b0;
      r_i_cap     <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_underrun  <= 1'b0;
`ifdef TX_UNDERRUN_HOLD_EN
      for (int k = 0; k < TX_CHANS; k++) begin
        r_hold_i[k] <= '0;
        r_hold_q[k] <= '0;
      end
`endif
    end else begin
      r_out_valid <= 1'b0;
      r_underrun  <= w_urun_evt;
      if (w_start) begin
        r_urun <= ~r_bank_full[w_play_bank];
        r_ch   <= '0;
      end
      if (w_rd && !r_urun) r_raddr <= r_raddr + BANK_L2'(1);
      if (w_cap_i) r_i_cap <= r_rdata;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_chan  <= r_ch;
        r_ch        <= r_ch + CW'(1);
        if (r_urun) begin
`ifdef TX_UNDERRUN_HOLD_EN
          r_out_i <= r_hold_i[r_ch];
          r_out_q <= r_hold_q[r_ch];
`else
          r_out_i <= '0;
          r_out_q <= '0;
`endif
        end else begin
          r_out_i <= r_i_cap;
          r_out_q <= r_rdata;
`ifdef TX_UNDERRUN_HOLD_EN
          r_hold_i[r_ch] <= r_i_cap;
          r_hold_q[r_ch] <= r_rdata;
`endif
        end
      end
      if (w_fend && !r_urun) begin
        if (w_drain) begin
          r_fcnt  <= '0;
          r_raddr <= '0;
        end else begin
          r_fcnt <= r_fcnt + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_samp_player.sv
// tb_tx_samp_player: directed scenarios for tx_samp_player with a frame
// scoreboard (expected frames queued at stimulus time, popped on out_valid).
module tb_tx_samp_player;

  localparam int unsigned DW = 16;

  logic          adc_clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          set_nsamps;
  logic [6:0]    nsamps_in;
  logic          commit;
  logic          samp_tick;
  logic          out_valid;
  logic [0:0]    out_chan;
  logic [DW-1:0] out_i;
  logic [DW-1:0] out_q;
  logic          srq;
  logic          srq_ack;
  logic          underrun;
  logic          full;

  typedef struct packed {
    logic [0:0]    ch;
    logic [DW-1:0] i;
    logic [DW-1:0] q;
  } frm_t;

  frm_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_urun = 0;

  tx_samp_player dut (
    .adc_clk    (adc_clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .set_nsamps (set_nsamps),
    .nsamps_in  (nsamps_in),
    .commit     (commit),
    .samp_tick  (samp_tick),
    .out_valid  (out_valid),
    .out_chan   (out_chan),
    .out_i      (out_i),
    .out_q      (out_q),
    .srq        (srq),
    .srq_ack    (srq_ack),
    .underrun   (underrun),
    .full       (full)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample outputs on the falling edge and retire frames.
  task automatic cyc();
    frm_t f;
    @(negedge adc_clk);
    if (underrun === 1'b1) n_urun++;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'(out_valid), 64'(0));
      end else begin
        f = sb.pop_front();
        chk("frame", 64'({out_chan, out_i, out_q}), 64'(f));
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic tick();
    samp_tick = 1'b1;
    cyc();
    samp_tick = 1'b0;
  endtask

  task automatic push_frame(input logic [DW-1:0] i0, input logic [DW-1:0] q0,
                            input logic [DW-1:0] i1, input logic [DW-1:0] q1);
    frm_t f;
    f.ch = 1'b0; f.i = i0; f.q = q0; sb.push_back(f);
    f.ch = 1'b1; f.i = i1; f.q = q1; sb.push_back(f);
  endtask

  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      wr_en   = 1'b1;
      wr_data = base + DW'(k);
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
  endtask

  task automatic set_ns(input logic [6:0] n);
    set_nsamps = 1'b1;
    nsamps_in  = n;
    cyc();
    set_nsamps = 1'b0;
  endtask

  task automatic ack();
    srq_ack = 1'b1;
    cyc();
    srq_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; set_nsamps = 1'b0; nsamps_in = '0;
    commit = 1'b0; samp_tick = 1'b0; srq_ack = 1'b0;
    run(2);
    chk("reset_outs", 64'({out_valid, underrun, full, out_chan, out_i, out_q}), 64'(0));
    chk("reset_srq", 64'(srq), 64'(1));
    reset = 1'b0;
    run(1);
    ack();
    chk("srq_ack_clear", 64'(srq), 64'(0));

    // Basic play: 4 frames of 2 channels from words 1..16.
    set_ns(7'd3);
    write_words(16'h0001, 16);
    do_commit();
    run(2);
    chk("t1_full", 64'(full), 64'(0));
    for (int f = 0; f < 4; f++)
      push_frame(DW'(4*f+1), DW'(4*f+2), DW'(4*f+3), DW'(4*f+4));
    for (int t = 0; t < 4; t++) begin
      tick();
      run(2);
      chk("t1_latency_pre", 64'(out_valid), 64'(0));
      cyc();
      chk("t1_latency", 64'(out_valid), 64'(1));
      if (t == 3) begin
        run(3);
        chk("t1_srq_before_drain", 64'(srq), 64'(0));
        cyc();
        chk("t1_srq_after_drain", 64'(srq), 64'(1));
        run(12);
      end else begin
        run(16);
      end
    end
    chk("t1_sb_empty", 64'(sb.size()), 64'(0));

    // Ping-pong: A then B committed, B follows A's drain.
    ack();
    set_ns(7'd1);
    write_words(16'h0100, 8);
    do_commit();
    run(2);
    chk("t2_full_after_a", 64'(full), 64'(0));
    write_words(16'h0200, 8);
    do_commit();
    cyc();
    chk("t2_full_set", 64'(full), 64'(1));
    wr_en = 1'b1; wr_data = 16'hDEAD;   // dropped while full
    cyc();
    wr_en = 1'b0;
    push_frame(16'h0100, 16'h0101, 16'h0102, 16'h0103);
    push_frame(16'h0104, 16'h0105, 16'h0106, 16'h0107);
    push_frame(16'h0200, 16'h0201, 16'h0202, 16'h0203);
    push_frame(16'h0204, 16'h0205, 16'h0206, 16'h0207);
    tick();
    run(19);
    chk("t2_srq_mid", 64'(srq), 64'(0));
    tick();
    run(6);
    srq_ack = 1'b1;
    cyc();
    srq_ack = 1'b0;
    chk("t2_srq_set_wins", 64'(srq), 64'(1));
    chk("t2_full_clear", 64'(full), 64'(0));
    run(12);
    ack();
    chk("t2_srq_ack_alone", 64'(srq), 64'(0));
    tick();
    run(19);
    tick();
    run(19);
    chk("t2_sb_empty", 64'(sb.size()), 64'(0));
    chk("t2_srq_b_drain", 64'(srq), 64'(1));

    // Underrun: no committed bank; then a tick while busy is dropped.
`ifdef TX_UNDERRUN_HOLD_EN
    push_frame(16'h0204, 16'h0205, 16'h0206, 16'h0207);
`else
    push_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000);
`endif
    tick();
    chk("t3_underrun_pulse", 64'(underrun), 64'(1));
    cyc();
    chk("t3_underrun_one_cycle", 64'(underrun), 64'(0));
    tick();
    chk("t3_busy_tick_underrun", 64'(underrun), 64'(1));
    run(20);
    chk("t3_sb_empty", 64'(sb.size()), 64'(0));

    // Overfill: 600 writes saturate at word 511 without touching the other bank.
    ack();
    set_ns(7'd127);
    write_words(16'h1000, 600);
    do_commit();
    run(2);
    for (int f = 0; f < 128; f++)
      push_frame(DW'(16'h1000 + 4*f), DW'(16'h1001 + 4*f),
                 DW'(16'h1002 + 4*f), DW'(16'h1003 + 4*f));
    for (int t = 0; t < 128; t++) begin
      tick();
      run(7);
    end
    run(4);
    chk("t4_sb_empty", 64'(sb.size()), 64'(0));
    chk("t4_srq_drain", 64'(srq), 64'(1));
    set_ns(7'd1);
    do_commit();
    run(2);
    push_frame(16'h0200, 16'h0201, 16'h0202, 16'h0203);
    push_frame(16'h0204, 16'h0205, 16'h0206, 16'h0207);
    tick();
    run(19);
    tick();
    run(19);
    chk("t4_other_bank_intact", 64'(sb.size()), 64'(0));

    // Reset during EMIT of ch1, then replay from word 0.
    ack();
    write_words(16'h0300, 8);
    do_commit();
    run(2);
    push_frame(16'h0300, 16'h0301, 16'h0302, 16'h0303);
    void'(sb.pop_back());                 // ch1 is cut off by reset
    tick();
    run(5);
    reset = 1'b1;
    #1;
    chk("t5_valid_async_low", 64'(out_valid), 64'(0));
    chk("t5_srq_async_set", 64'(srq), 64'(1));
    run(2);
    reset = 1'b0;
    cyc();
    chk("t5_sb_empty_after_reset", 64'(sb.size()), 64'(0));
    chk("t5_full_reset", 64'(full), 64'(0));
    write_words(16'h0400, 4);
    do_commit();
    run(2);
    push_frame(16'h0400, 16'h0401, 16'h0402, 16'h0403);
    tick();
    run(19);
    chk("t5_replay_sb_empty", 64'(sb.size()), 64'(0));
    chk("total_underruns", 64'(n_urun), 64'(2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
